// File: rtl/game_pkg.sv
// Shared types and widths for the game score keeper.
package game_pkg;

  localparam int POINTS_W = 14;
  localparam int LIVES_W  = 2;
  localparam int TIME_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WON  = 2'd2,
    ST_LOST = 2'd3
  } game_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer for a raw button plus a registered rising-edge pulse.
// A held button yields a single pulse; a re-press needs one low sample first.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;
  logic pulse_reg;

  // Synchronize, remember the previous synchronized level, register the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      pulse_reg <= sync2_reg & ~prev_reg;
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/game_score_keeper.sv
// Game-state stage feeding the seven-segment driver: points, lives, a
// per-round countdown and the IDLE/PLAY/WON/LOST state machine.
module game_score_keeper
  import game_pkg::*;
#(
  parameter int TICK_DIV      = 100_000_000,
  parameter int ROUND_SECONDS = 10,
  parameter int START_LIVES   = 3,
  parameter int WIN_POINTS    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_btn,
  input  logic        hit_btn,
  input  logic        miss_btn,
  output logic [15:0] displayNumber,
  output logic [1:0]  displayScore,
  output logic [7:0]  round_time,
  output logic [1:0]  game_state
);

  localparam int PRE_W = $clog2(TICK_DIV);

  localparam logic [PRE_W-1:0]    PRESC_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [POINTS_W-1:0] WIN_P     = POINTS_W'(WIN_POINTS);
  localparam logic [LIVES_W-1:0]  START_L   = LIVES_W'(START_LIVES);
  localparam logic [TIME_W-1:0]   ROUND_T   = TIME_W'(ROUND_SECONDS);

  // Button conditioning: index 0 = start, 1 = hit, 2 = miss.
  logic [2:0] btn_raw;
  logic [2:0] btn_p;

  assign btn_raw = {miss_btn, hit_btn, start_btn};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      btn_sync_edge u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_raw[gi]),
        .pulse (btn_p[gi])
      );
    end
  endgenerate

  logic start_p;
  logic hit_p;
  logic miss_p;

  assign start_p = btn_p[0];
  assign hit_p   = btn_p[1];
  assign miss_p  = btn_p[2];

  game_state_t         state_reg,  state_next;
  logic [POINTS_W-1:0] points_reg, points_next;
  logic [LIVES_W-1:0]  lives_reg,  lives_next;
  logic [TIME_W-1:0]   time_reg,   time_next;
  logic [PRE_W-1:0]    presc_reg,  presc_next;

  logic tick;
  logic timeout;

  assign tick    = (state_reg == ST_PLAY) && (presc_reg == PRESC_MAX);
  assign timeout = tick && (time_reg == TIME_W'(1));

  // Resolve one cycle of events: start > hit > miss/timeout > plain tick.
  always_comb begin
    state_next  = state_reg;
    points_next = points_reg;
    lives_next  = lives_reg;
    time_next   = time_reg;
    presc_next  = presc_reg;

    if (start_p) begin
      state_next  = ST_PLAY;
      points_next = '0;
      lives_next  = START_L;
      time_next   = ROUND_T;
      presc_next  = '0;
    end else if (state_reg == ST_PLAY) begin
      presc_next = tick ? '0 : presc_reg + PRE_W'(1);
      if (hit_p) begin
        // A hit swallows any coincident miss or timeout.
        points_next = points_reg + POINTS_W'(1);
        time_next   = ROUND_T;
        presc_next  = '0;
        if (points_reg + POINTS_W'(1) == WIN_P) begin
          state_next = ST_WON;
        end
      end else if (miss_p || timeout) begin
        // Miss and timeout together still cost only one life.
        lives_next = lives_reg - LIVES_W'(1);
        time_next  = ROUND_T;
        if (timeout) begin
          presc_next = '0;
        end
        if (lives_reg == LIVES_W'(1)) begin
          state_next = ST_LOST;
        end
      end else if (tick) begin
        time_next = time_reg - TIME_W'(1);
      end
    end
  end

  // Game state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      points_reg <= '0;
      lives_reg  <= START_L;
      time_reg   <= ROUND_T;
      presc_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      points_reg <= points_next;
      lives_reg  <= lives_next;
      time_reg   <= time_next;
      presc_reg  <= presc_next;
    end
  end

  assign displayNumber = {{(16 - POINTS_W){1'b0}}, points_reg};
  assign displayScore  = lives_reg;
  assign round_time    = time_reg;
  assign game_state    = state_reg;

endmodule
